// File: rtl/ncl_wave_seq.sv
// ncl_wave_seq
//
// Clocked wavefront sequencer for one NCL combinational stage. A single-rail
// word accepted over a valid/ready handshake is driven into the stage as a
// dual-rail DATA wavefront. When every output pair of the stage carries a
// valid code, the true rails are captured as the result and offered over a
// second handshake. Once the result is taken, a NULL wavefront is driven and
// the sequencer waits for all output pairs to return to 00 before accepting
// the next word. Phase timeouts and illegal rail codes (t=f=1) park the block
// in an error state until err_clr.
//
// Optional feature macro: NCL_SEQ_SYNC_EN
//   defined   : stage outputs pass a 2-flop synchronizer, and completion also
//               requires the sampled code to match on two consecutive cycles.
//   undefined : stage outputs are sampled by a single register stage.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input word handshake, in_data = single-rail word
//   rail_t/rail_f       dual-rail drive to the NCL stage
//   dut_t/dut_f         dual-rail outputs of the stage (asynchronous to clk)
//   out_valid/out_ready result handshake, out_data = decoded result
//   busy                sequencer not idle
//   err, err_code       sticky error flag and cause (1 DATA timeout,
//                       2 NULL timeout, 3 illegal code)
//   err_clr             leaves the error state
module ncl_wave_seq #(
    parameter int WIDTH   = 4,
    parameter int OWIDTH  = 1,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic [WIDTH-1:0]  rail_t,
    output logic [WIDTH-1:0]  rail_f,
    input  logic [OWIDTH-1:0] dut_t,
    input  logic [OWIDTH-1:0] dut_f,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OWIDTH-1:0] out_data,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              err_clr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_DATA = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_NULL = 3'd3;
    localparam logic [2:0] ST_ERR  = 3'd4;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [OWIDTH-1:0] samp_t;
    logic [OWIDTH-1:0] samp_f;
    logic              stable;

`ifdef NCL_SEQ_SYNC_EN
    logic [OWIDTH-1:0] sync_t;
    logic [OWIDTH-1:0] sync_f;
    logic [OWIDTH-1:0] prev_t;
    logic [OWIDTH-1:0] prev_f;

    // Two-flop synchronizer followed by a history register; the history lets
    // completion ignore a code that is still settling across skewed rails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_t <= '0;
            sync_f <= '0;
            samp_t <= '0;
            samp_f <= '0;
            prev_t <= '0;
            prev_f <= '0;
        end else begin
            sync_t <= dut_t;
            sync_f <= dut_f;
            samp_t <= sync_t;
            samp_f <= sync_f;
            prev_t <= samp_t;
            prev_f <= samp_f;
        end
    end

    assign stable = (samp_t == prev_t) && (samp_f == prev_f);
`else
    // Single sampling register; completion is judged on this one sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_t <= '0;
            samp_f <= '0;
        end else begin
            samp_t <= dut_t;
            samp_f <= dut_f;
        end
    end

    assign stable = 1'b1;
`endif

    logic illegal;
    logic data_done;
    logic null_done;
    logic timed_out;

    // A pair with both rails high is never a legal in-flight code.
    assign illegal   = |(samp_t & samp_f);
    assign data_done = stable && (&(samp_t ^ samp_f));
    assign null_done = stable && !(|(samp_t | samp_f));
    // The counter starts at 0 on phase entry, so TIMEOUT-1 marks the
    // TIMEOUT-th cycle spent in the phase.
    assign timed_out = (cnt == TO_LAST);

    // Wavefront sequencing. Rails are registers so the stage sees glitch-free
    // drive, and reset returns them to NULL without waiting for a clock.
    // Illegal codes are checked before completion and timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rail_t   <= '0;
            rail_f   <= '0;
            out_data <= '0;
            err_code <= 2'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        rail_t <= in_data;
                        rail_f <= ~in_data;
                        cnt    <= '0;
                        state  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (illegal) begin
                        rail_t   <= '0;
                        rail_f   <= '0;
                        err_code <= 2'd3;
                        state    <= ST_ERR;
                    end else if (data_done) begin
                        out_data <= samp_t;
                        state    <= ST_HOLD;
                    end else if (timed_out) begin
                        rail_t   <= '0;
                        rail_f   <= '0;
                        err_code <= 2'd1;
                        state    <= ST_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (illegal) begin
                        rail_t   <= '0;
                        rail_f   <= '0;
                        err_code <= 2'd3;
                        state    <= ST_ERR;
                    end else if (out_ready) begin
                        rail_t <= '0;
                        rail_f <= '0;
                        cnt    <= '0;
                        state  <= ST_NULL;
                    end
                end
                ST_NULL: begin
                    if (illegal) begin
                        err_code <= 2'd3;
                        state    <= ST_ERR;
                    end else if (null_done) begin
                        state <= ST_IDLE;
                    end else if (timed_out) begin
                        err_code <= 2'd2;
                        state    <= ST_ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ERR: begin
                    if (err_clr) begin
                        err_code <= 2'd0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    rail_t <= '0;
                    rail_f <= '0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign err       = (state == ST_ERR);

endmodule

// File: tb/tb_ncl_wave_seq.sv
// tb_ncl_wave_seq
//
// Bench for ncl_wave_seq with WIDTH=4, OWIDTH=1, TIMEOUT=8. The NCL stage is
// modelled as a weighted 3-of-4 threshold gate (bit 0 weighs 2, the others 1)
// with hysteresis and a 2-cycle delay. A stage_mode variable lets scenarios
// force the stage outputs stuck at NULL, stuck at DATA, or to the illegal 11 code.
module tb_ncl_wave_seq;

    localparam int WIDTH   = 4;
    localparam int OWIDTH  = 1;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data = '0;
    logic [WIDTH-1:0]  rail_t;
    logic [WIDTH-1:0]  rail_f;
    logic [OWIDTH-1:0] dut_t;
    logic [OWIDTH-1:0] dut_f;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [OWIDTH-1:0] out_data;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;
    logic              err_clr = 1'b0;

    int pass_count  = 0;
    int check_count = 0;
    int stage_mode  = 0;

    ncl_wave_seq #(.WIDTH(WIDTH), .OWIDTH(OWIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rail_t(rail_t), .rail_f(rail_f),
        .dut_t(dut_t), .dut_f(dut_f),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err(err), .err_code(err_code), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Result the stage should produce for a single-rail word.
    function automatic logic ref_thresh(input logic [3:0] w);
        int s;
        s = 2 * int'(w[0]) + int'(w[1]) + int'(w[2]) + int'(w[3]);
        return (s >= 3);
    endfunction

    // Stage model: switches to DATA only when all input pairs are valid, to
    // NULL only when all are 00, otherwise holds (hysteresis).
    logic [OWIDTH-1:0] p1_t = '0, p1_f = '0, p2_t = '0, p2_f = '0;

    always @(posedge clk) begin
        if (rail_t == '0 && rail_f == '0) begin
            p1_t <= 1'b0;
            p1_f <= 1'b0;
        end else if ((rail_t ^ rail_f) == 4'hF) begin
            p1_t <= ref_thresh(rail_t);
            p1_f <= !ref_thresh(rail_t);
        end
        p2_t <= p1_t;
        p2_f <= p1_f;
    end

    always_comb begin
        dut_t = p2_t;
        dut_f = p2_f;
        case (stage_mode)
            1: begin dut_t = 1'b0; dut_f = 1'b0; end
            2: begin dut_t = 1'b1; dut_f = 1'b0; end
            3: begin dut_t = 1'b1; dut_f = 1'b1; end
            default: ;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait: which 0 = in_ready, 1 = out_valid, 2 = err.
    task automatic wait_for(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if ((which == 0 && in_ready) || (which == 1 && out_valid) ||
                (which == 2 && err)) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Full transaction for one word, ready_delay cycles of back-pressure.
    task automatic send_word(input logic [3:0] word, input int ready_delay);
        bit ok;
        logic exp;
        exp = ref_thresh(word);
        wait_for(0, ok);
        check_count++;
        if (!ok) $display("[TB] FAIL idle_wait: in_ready=%0b required 1", in_ready);
        else pass_count++;
        in_data  = word;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_count++;
        if ({busy, rail_t, rail_f} !== {1'b1, word, ~word})
            $display("[TB] FAIL accept_rails: got busy=%0b t=%h f=%h required 1 %h %h",
                     busy, rail_t, rail_f, word, ~word);
        else pass_count++;
        wait_for(1, ok);
        check_count++;
        if (!ok || out_data !== exp)
            $display("[TB] FAIL result: word=%h out_valid=%0b out_data=%0b required 1 %0b",
                     word, out_valid, out_data, exp);
        else pass_count++;
        for (int i = 0; i < ready_delay; i++) begin
            tick();
            check_count++;
            if ({out_valid, out_data, rail_t, rail_f} !== {1'b1, exp, word, ~word})
                $display("[TB] FAIL hold_stable: got %0b %0b %h %h required 1 %0b %h %h",
                         out_valid, out_data, rail_t, rail_f, exp, word, ~word);
            else pass_count++;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_count++;
        if ({out_valid, rail_t, rail_f} !== 9'd0)
            $display("[TB] FAIL null_rails: got out_valid=%0b t=%h f=%h required 0 0 0",
                     out_valid, rail_t, rail_f);
        else pass_count++;
        wait_for(0, ok);
        check_count++;
        if (!ok || busy !== 1'b0)
            $display("[TB] FAIL null_done: in_ready=%0b busy=%0b required 1 0", in_ready, busy);
        else pass_count++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_count++;
        if ({in_ready, out_valid, busy, err, err_code, rail_t, rail_f, out_data} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0})
            $display("[TB] FAIL reset_values: rdy=%0b ov=%0b busy=%0b err=%0b code=%0d t=%h f=%h od=%0b required 1 0 0 0 0 0 0 0",
                     in_ready, out_valid, busy, err, err_code, rail_t, rail_f, out_data);
        else pass_count++;
        rst_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_basic();
        send_word(4'b0011, 0);
    endtask

    task automatic test_hold();
        send_word(4'b0001, 10);
    endtask

    // Common body for both timeout scenarios: counts cycles after phase entry.
    task automatic expect_timeout(input logic [1:0] code);
        for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            check_count++;
            if (i < TIMEOUT) begin
                if (err !== 1'b0)
                    $display("[TB] FAIL early_timeout: cycle %0d err=%0b required 0", i, err);
                else pass_count++;
            end else begin
                if ({err, err_code, rail_t, rail_f, in_ready, out_valid} !==
                    {1'b1, code, 8'h00, 1'b0, 1'b0})
                    $display("[TB] FAIL timeout: err=%0b code=%0d t=%h f=%h rdy=%0b ov=%0b required 1 %0d 0 0 0 0",
                             err, err_code, rail_t, rail_f, in_ready, out_valid, code);
                else pass_count++;
            end
        end
        stage_mode = 0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check_count++;
        if ({in_ready, err, err_code} !== {1'b1, 1'b0, 2'd0})
            $display("[TB] FAIL err_clr: rdy=%0b err=%0b code=%0d required 1 0 0",
                     in_ready, err, err_code);
        else pass_count++;
        repeat (4) tick();
    endtask

    task automatic test_timeout_data();
        bit ok;
        stage_mode = 1;
        wait_for(0, ok);
        in_data  = 4'b0011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        expect_timeout(2'd1);
    endtask

    task automatic test_timeout_null();
        bit ok;
        wait_for(0, ok);
        in_data  = 4'b1010;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_for(1, ok);
        check_count++;
        if (!ok) $display("[TB] FAIL hold_reach: out_valid=%0b required 1", out_valid);
        else pass_count++;
        stage_mode = 2;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        expect_timeout(2'd2);
    endtask

    task automatic test_illegal();
        bit ok;
        wait_for(0, ok);
        in_data  = 4'b1111;
        in_valid = 1'b1;
        tick();
        in_valid   = 1'b0;
        stage_mode = 3;
        wait_for(2, ok);
        check_count++;
        if (!ok || {err_code, rail_t, rail_f, out_valid} !== {2'd3, 8'h00, 1'b0})
            $display("[TB] FAIL illegal: err=%0b code=%0d t=%h f=%h ov=%0b required 1 3 0 0 0",
                     err, err_code, rail_t, rail_f, out_valid);
        else pass_count++;
        stage_mode = 0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset_hold();
        bit ok;
        wait_for(0, ok);
        in_data  = 4'b0011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_for(1, ok);
        rst_n = 1'b0;
        #1;
        check_count++;
        if ({out_valid, busy, rail_t, rail_f} !== 10'd0)
            $display("[TB] FAIL async_reset: ov=%0b busy=%0b t=%h f=%h required 0 0 0 0",
                     out_valid, busy, rail_t, rail_f);
        else pass_count++;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        send_word(4'b1111, 1);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [3:0] w1, w2;
        w1 = 4'($urandom_range(0, 15));
        w2 = ~w1;
        wait_for(0, ok);
        in_data  = w1;
        in_valid = 1'b1;
        tick();
        in_data = w2;
        wait_for(1, ok);
        tick();
        check_count++;
        if ({out_valid, rail_t} !== {1'b1, w1})
            $display("[TB] FAIL b2b_hold: ov=%0b t=%h required 1 %h", out_valid, rail_t, w1);
        else pass_count++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_for(0, ok);
        tick();
        in_valid = 1'b0;
        check_count++;
        if ({busy, rail_t, rail_f} !== {1'b1, w2, ~w2})
            $display("[TB] FAIL b2b_accept: busy=%0b t=%h f=%h required 1 %h %h",
                     busy, rail_t, rail_f, w2, ~w2);
        else pass_count++;
        wait_for(1, ok);
        check_count++;
        if (!ok || out_data !== ref_thresh(w2))
            $display("[TB] FAIL b2b_result: od=%0b required %0b", out_data, ref_thresh(w2));
        else pass_count++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_for(0, ok);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_word(4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic();
        test_hold();
        test_timeout_data();
        test_timeout_null();
        test_illegal();
        test_reset_hold();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ncl_wave_seq.md
# ncl_wave_seq

Clocked wavefront sequencer for functional simulation and FPGA prototyping of NCL threshold-gate datapaths built from the static cell library (th-gate stages with hysteresis). It accepts single-rail words over a valid/ready handshake, drives them into the NCL stage as dual-rail DATA followed by NULL wavefronts, and detects completion of each output wavefront. It returns the decoded result over a second handshake and flags timeouts and illegal rail codes. It sits between a synchronous testbench or host and one NCL combinational stage.

## Interface
- WIDTH, 4, input word width; dual-rail pairs driven to the stage
- OWIDTH, 1, output word width; dual-rail pairs returned by the stage
- TIMEOUT, 64, maximum cycles allowed in DATA or NULL phase before error; ≥2
- clk  in  1  single clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input word offered
- in_ready  out  1  sequencer can accept a word
- in_data  in  WIDTH  single-rail input word
- rail_t / rail_f  out  WIDTH each  dual-rail drive to the NCL stage (true/false rails)
- dut_t / dut_f  in  OWIDTH each  dual-rail outputs of the NCL stage; asynchronous to clk
- out_valid  out  1  decoded result available
- out_ready  in  1  consumer accepts result
- out_data  out  OWIDTH  decoded result: dut_t value captured at DATA completion
- busy  out  1  state ≠ IDLE
- err  out  1  sticky error flag
- err_code  out  2  0 none, 1 DATA timeout, 2 NULL timeout, 3 illegal code (t=f=1)
- err_clr  in  1  clears error; leaves ERR state

## Operation
- States: IDLE, DATA, HOLD, NULL, ERR.
- IDLE: rails all 0 (NULL); in_ready=1. On in_valid&in_ready, register in_data and go to DATA.
- DATA: rail_t=word, rail_f=~word. Complete when every sampled output pair has exactly one rail high. On completion, capture dut_t into out_data and go to HOLD.
- HOLD: rails held at DATA; out_valid=1. On out_ready, go to NULL.
- NULL: rails all 0. Complete when every sampled pair is 00. On completion, go to IDLE.
- Timeout counter: cleared on each DATA/NULL entry; increments each cycle in DATA/NULL. Reaching TIMEOUT with no completion goes to ERR with code 1 (DATA) or 2 (NULL).
- Any sampled pair with t=f=1 while in DATA, HOLD or NULL goes to ERR with code 3. Illegal code takes priority over completion and timeout in the same cycle.
- ERR: rails all 0; err=1; in_ready=0; out_valid=0. err_clr returns to IDLE and clears err and err_code. err_clr is ignored in other states.
- Partial codes (some pairs still 00 in DATA, some still valid in NULL) are normal in-flight states, not errors.

## Timing
- Reset values: state IDLE, rails 0, in_ready 1, out_valid 0, out_data 0, busy 0, err 0, err_code 0, counter 0.
- Reset mid-operation: rails drop to NULL immediately (asynchronously); any in-flight word is discarded.
- Accept → rails DATA: 1 cycle (rails registered).
- Sampled completion → out_valid: 1 cycle.
- out_ready in HOLD → rails NULL on the next edge.
- NULL completion → in_ready: 1 cycle. Back-to-back throughput is therefore 4 + stage delays + 2×SYNC cycles per word.
- out_valid stays high and out_data stays stable until accepted.
- If in_valid is held, the next word is accepted in the first IDLE cycle.

## Configuration
- NCL_SEQ_SYNC_EN defined: dut_t/dut_f pass through a 2-flop synchronizer before completion and illegal-code detection. Each sampled event arrives 2 cycles later (SYNC=2). Completion additionally requires the sampled code to be equal on two consecutive cycles, which filters rail skew.
- NCL_SEQ_SYNC_EN undefined: dut rails are sampled directly in one register stage (SYNC=0). There is no stability check; completion is evaluated on that single sample.

## Test plan
- WIDTH=4, OWIDTH=1, stage modelled as 3-of-4 weighted threshold with 2-cycle delay. Send 4'b0011 → rails_t=0011, rails_f=1100; out_data=1, then a NULL wave, then in_ready=1.
- Send 4'b0001 → out_data=0. Hold out_ready=0 for 10 cycles → rails stay at DATA and out_valid stays 1 throughout.
- Stage stuck at NULL, TIMEOUT=8 → err=1 and err_code=1 exactly 8 cycles after DATA entry; rails 0; err_clr → IDLE, in_ready=1.
- Stage output stuck at DATA after HOLD → err_code=2 after 8 NULL cycles.
- Force dut_t=dut_f=1 during DATA → err_code=3 on the next sample, even when the same cycle would also satisfy completion.
- Assert rst_n=0 during HOLD → rails 0, out_valid 0 asynchronously; after release, a fresh 4'b1111 completes with out_data=1.
